// File: rtl/clk_div_pkg.sv
// Shared types, default widths and helpers for the run-time 2N clock divider.
package clk_div_pkg;

  localparam int CLK_DIV_CNT_W    = 16;
  localparam int CLK_DIV_BURST_W  = 8;
  localparam int CLK_DIV_DEF_HALF = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2
  } state_t;

  // A half-period of zero cannot be counted, so it is promoted to one (divide by 2).
  function automatic logic [31:0] sat_half(input logic [31:0] x);
    return (x == 32'd0) ? 32'd1 : x;
  endfunction

endpackage

// File: rtl/clk_div_ctrl_if.sv
// Configuration handshake bundle: divide ratio and burst length offered over valid/ready.
interface clk_div_ctrl_if #(
  parameter int CNT_W   = 16,
  parameter int BURST_W = 8
);
  logic               cfg_valid;
  logic               cfg_ready;
  logic [CNT_W-1:0]   cfg_half;
  logic [BURST_W-1:0] cfg_cycles;

  modport master (output cfg_valid, cfg_half, cfg_cycles, input cfg_ready);
  modport slave  (input cfg_valid, cfg_half, cfg_cycles, output cfg_ready);
endinterface

// File: rtl/clk_div_core.sv
// Half-period counter and toggle flop; reports when the current phase ends this cycle.
module clk_div_core #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             restart,
  input  logic [CNT_W-1:0] half,
  output logic             clk_out,
  output logic             toggle_rise,
  output logic             toggle_fall
);

  logic [CNT_W-1:0] cnt;
  logic             phase_end;

  // >= rather than == so a freshly shrunk half ends the phase at once instead of wrapping
  assign phase_end   = (cnt >= (half - CNT_W'(1)));
  assign toggle_rise = phase_end && !clk_out;
  assign toggle_fall = phase_end && clk_out;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt     <= '0;
      clk_out <= 1'b0;
    end else if (restart) begin
      cnt     <= '0;
      clk_out <= 1'b1;
    end else if (!en) begin
      cnt     <= '0;
      clk_out <= 1'b0;
    end else if (phase_end) begin
      cnt     <= '0;
      clk_out <= ~clk_out;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/clk_div_ctrl.sv
// Sequencer for the divider: config/shadow registers, start/stop FSM, burst counter, strobes.
module clk_div_ctrl
  import clk_div_pkg::*;
#(
  parameter int CNT_W    = CLK_DIV_CNT_W,
  parameter int BURST_W  = CLK_DIV_BURST_W,
  parameter int DEF_HALF = CLK_DIV_DEF_HALF
) (
  input  logic           clk,
  input  logic           reset,
  clk_div_ctrl_if.slave  cfg,
  input  logic           start,
  input  logic           stop,
  output logic           busy,
  output logic           clk_out,
  output logic           rise_stb,
  output logic           fall_stb,
  output logic           done
);

  state_t             state, nxt;
  logic [CNT_W-1:0]   half_reg, sh_half, new_half;
  logic [BURST_W-1:0] cyc_reg, sh_cyc, eff_cyc, remain;
  logic               pending, burst;
  logic               accept, apply_sh, last;
  logic               en, restart, toggle_rise, toggle_fall;
  logic               rise_d, fall_d, done_d, dec;

  assign cfg.cfg_ready = !pending;
  assign busy          = (state != IDLE);
  assign accept        = cfg.cfg_valid && cfg.cfg_ready;
  assign new_half      = CNT_W'(sat_half(32'(cfg.cfg_half)));
  // In IDLE a waiting shadow has no falling edge to wait for, so it is applied right away
  assign apply_sh      = pending && ((state == IDLE) || toggle_fall);
  assign last          = burst && (remain == BURST_W'(1));

  always_comb begin
    eff_cyc = cyc_reg;
    if (state == IDLE && accept)
      eff_cyc = cfg.cfg_cycles;
    else if (state == IDLE && pending)
      eff_cyc = sh_cyc;
  end

  clk_div_core #(.CNT_W(CNT_W)) u_core (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .restart     (restart),
    .half        (half_reg),
    .clk_out     (clk_out),
    .toggle_rise (toggle_rise),
    .toggle_fall (toggle_fall)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      rise_stb <= 1'b0;
      fall_stb <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= nxt;
      rise_stb <= rise_d;
      fall_stb <= fall_d;
      done     <= done_d;
    end
  end

  always_comb begin
    nxt     = state;
    en      = 1'b0;
    restart = 1'b0;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    done_d  = 1'b0;
    dec     = 1'b0;
    case (state)
      IDLE: begin
        if (start && !stop) begin
          nxt     = RUN;
          restart = 1'b1;
          rise_d  = 1'b1;
        end
      end
      RUN: begin
        if (stop && !clk_out) begin
          nxt    = IDLE;
          done_d = 1'b1;
        end else if (toggle_fall) begin
          fall_d = 1'b1;
          dec    = burst;
          if (last || stop) begin
            nxt    = IDLE;
            done_d = 1'b1;
          end else begin
            en = 1'b1;
          end
        end else if (stop) begin
          nxt = STOPPING;
          en  = 1'b1;
        end else begin
          en     = 1'b1;
          rise_d = toggle_rise;
        end
      end
      STOPPING: begin
        if (toggle_fall) begin
          nxt    = IDLE;
          fall_d = 1'b1;
          done_d = 1'b1;
        end else begin
          en = 1'b1;
        end
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      half_reg <= CNT_W'(DEF_HALF);
      cyc_reg  <= '0;
      pending  <= 1'b0;
      burst    <= 1'b0;
    end else begin
      if (state == IDLE && accept) begin
        half_reg <= new_half;
        cyc_reg  <= cfg.cfg_cycles;
      end else if (apply_sh) begin
        half_reg <= sh_half;
        cyc_reg  <= sh_cyc;
        pending  <= 1'b0;
      end
      if (state != IDLE && accept)
        pending <= 1'b1;
      if (restart)
        burst <= (eff_cyc != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (state != IDLE && accept) begin
      sh_half <= new_half;
      sh_cyc  <= cfg.cfg_cycles;
    end
    if (restart)
      remain <= eff_cyc;
    else if (dec)
      remain <= remain - BURST_W'(1);
  end

endmodule

// File: doc/clk_div_ctrl.md
Name: clk_div_ctrl

Overview:
Run-time controller and sequencer for the 2N clock divider used by the RFID front end. It accepts divide-ratio and burst-length settings over a valid/ready handshake, and starts and stops the divided clock without runt pulses. It produces bursts of a programmed number of output periods, or continuous output, for carrier and modulation timing. It replaces the fixed divider at places where software or a protocol FSM must change the ratio while running.

Parameters:
CNT_W, 16, width of the half-period count in input clocks
BURST_W, 8, width of the burst length in output periods
DEF_HALF, 4, half-period after reset (divide by 8)

Ports:
clk  in  1  system clock; all logic on rising edge
reset  in  1  asynchronous, active-high reset
cfg_valid  in  1  config offer
cfg_ready  out  1  config can be accepted
cfg_half  in  CNT_W  half-period in clk cycles; 0 treated as 1
cfg_cycles  in  BURST_W  output periods per burst; 0 = continuous
start  in  1  begin output (level sampled, acts only in IDLE)
stop  in  1  request orderly stop
busy  out  1  state != IDLE
clk_out  out  1  divided clock, registered
rise_stb  out  1  high in first clk cycle clk_out is 1
fall_stb  out  1  high in first clk cycle clk_out is 0 after a high phase
done  out  1  one-cycle pulse when a burst or stop completes

Behaviour:
- Reset (asynchronous, immediate, also mid-operation):
  - state=IDLE; clk_out, rise_stb, fall_stb, done, busy = 0.
  - cfg_ready=1; half_reg=DEF_HALF; cyc_reg=0; no config pending; cnt=0.
- Config handshake:
  - Transfer occurs when cfg_valid && cfg_ready.
  - In IDLE: half_reg and cyc_reg load at that edge.
  - In RUN or STOPPING: the values go to a shadow register and a pending flag is set; cfg_ready=0 while pending.
  - The shadow is applied at the next falling toggle of clk_out. The low phase that begins there already uses the new half. A new cyc_reg reloads the remaining count only at the next start.
- States: IDLE, RUN, STOPPING.
- IDLE:
  - clk_out=0.
  - If start && !stop, at the next edge: state=RUN, clk_out=1, rise_stb=1, cnt=0, remain=cyc_reg.
  - If cfg is accepted in the same cycle as start, the new values are used (bypass).
  - start && stop together: stays IDLE.
- RUN:
  - cnt counts 0..half-1 within each phase; at cnt==half-1, cnt=0 and clk_out toggles.
  - Output period is exactly 2*half clk cycles; half=1 gives divide by 2.
  - On each falling toggle with cyc_reg!=0, remain decrements.
  - When remain reaches 0 at a falling toggle: IDLE, with done=1 and fall_stb=1 in the same cycle.
  - start while busy is ignored.
- stop in RUN:
  - If clk_out=0: next edge goes to IDLE, done=1, no further rise.
  - If clk_out=1: go to STOPPING. Finish the high phase, then at the falling toggle go to IDLE with done=1 and fall_stb=1.
  - stop during STOPPING has no extra effect.
  - Burst end and stop in the same cycle: a single done pulse.
- Strobes are registered and coincide with the clk_out level change. Never assert two strobes in the same cycle except fall_stb with done.
- cnt never exceeds half-1. If the applied half is smaller than the current cnt, the phase ends at the next cycle (no wrap through 2^CNT_W).

Decomposition:
- Package clk_div_pkg:
  - state enum {IDLE, RUN, STOPPING}
  - DEF_HALF, CNT_W, BURST_W defaults
  - function sat_half(x) that maps 0 to 1
- One natural sub-module, clk_div_core: the half-period counter and toggle flop.
  - Inputs: en, half, restart.
  - Outputs: clk_out, toggle_rise, toggle_fall.
- clk_div_ctrl holds the FSM, config/shadow registers, burst counter and strobes.

Test Plan:
1. Reset then idle: assert reset mid-RUN with clk_out=1 -> clk_out=0, busy=0, cfg_ready=1 immediately; after release, half=4 (start gives 4-high/4-low).
2. Burst: cfg half=5, cycles=3; start at edge E0 -> rise at E1, falls at E1+5/+15/+25; exactly 3 rise_stb and 3 fall_stb; done and busy=0 at E1+25.
3. Divide-by-2: half=1, cycles=0, start -> clk_out toggles every clk; stop while clk_out=1 -> one more low transition, done, IDLE; no runt.
4. Live reconfig: continuous half=2; offer half=3 during a high phase -> cfg_ready=0 until the next fall; then low phase=3, following periods 6 clks; cfg_ready returns to 1.
5. Corner handshakes: start+stop together in IDLE -> stays IDLE; cfg half=0 -> behaves as half=1; start while busy -> ignored, burst count unchanged.
6. Stop in low phase: half=4 continuous, stop at cnt=1 of the low phase -> next edge IDLE, done=1, clk_out stays 0, no rise_stb.
